// File: rtl/dtree_serial_engine_if.sv
// Handshake and configuration bundle for the serial decision-tree engine.
// The master side feeds samples and node words; the slave side is the engine.
interface dtree_serial_engine_if #(
   parameter int NUM_FEAT = 9,
   parameter int FEAT_W   = 8,
   parameter int NODE_AW  = 6,
   parameter int CLASS_W  = 2
);
   localparam int NW = 1 + 4 + FEAT_W + 2 * NODE_AW;

   logic                         cfg_we;
   logic [NODE_AW-1:0]           cfg_addr;
   logic [NW-1:0]                cfg_wdata;
   logic                         cfg_err;
   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_FEAT*FEAT_W-1:0]   in_x;
   logic                         out_valid;
   logic                         out_ready;
   logic [CLASS_W-1:0]           out_class;
   logic                         out_err;
   logic [3:0]                   out_depth;
   logic                         busy;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
      input  cfg_err, in_ready, out_valid, out_class, out_err, out_depth, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
      output cfg_err, in_ready, out_valid, out_class, out_err, out_depth, busy
   );
endinterface

// File: rtl/dtree_serial_engine.sv
// Table-driven decision-tree classifier walking one node per clock through a
// run-time programmable node table, sharing a single feature mux and comparator.
module dtree_serial_engine #(
   parameter int NUM_FEAT  = 9,
   parameter int FEAT_W    = 8,
   parameter int NODE_AW   = 6,
   parameter int CLASS_W   = 2,
   parameter int MAX_DEPTH = 15
) (
   input logic clk,
   input logic rst_n,
   dtree_serial_engine_if.slave bus
);
   localparam int NW    = 1 + 4 + FEAT_W + 2 * NODE_AW;
   localparam int NODES = 2 ** NODE_AW;
   localparam logic [4:0] NUM_FEAT_L = 5'(NUM_FEAT);
   localparam logic [3:0] MAX_DEPTH_L = 4'(MAX_DEPTH);

   typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

   state_t                     r_state;
   state_t                     w_nextState;
   logic [NW-1:0]              r_table [NODES];
   logic [NUM_FEAT*FEAT_W-1:0] r_sample;
   logic [NODE_AW-1:0]         r_curAddr;
   logic [3:0]                 r_depth;
   logic [CLASS_W-1:0]         r_outClass;
   logic                       r_outErr;
   logic [3:0]                 r_outDepth;
   logic                       r_cfgErr;

   logic [NW-1:0]              w_node;
   logic                       w_isInt;
   logic [3:0]                 w_featIdx;
   logic [FEAT_W-1:0]          w_thr;
   logic [NODE_AW-1:0]         w_left;
   logic [NODE_AW-1:0]         w_right;
   logic [CLASS_W-1:0]         w_leafClass;
   logic [FEAT_W-1:0]          w_feat;
   logic                       w_badFeat;
   logic                       w_depthMax;
   logic                       w_goLeft;

   assign w_node      = r_table[r_curAddr];
   assign w_isInt     = w_node[NW-1];
   assign w_featIdx   = w_node[NW-2 -: 4];
   assign w_thr       = w_node[NW-6 -: FEAT_W];
   assign w_left      = w_node[2*NODE_AW-1 -: NODE_AW];
   assign w_right     = w_node[NODE_AW-1:0];
   assign w_leafClass = w_node[CLASS_W-1:0];
   assign w_badFeat   = {1'b0, w_featIdx} >= NUM_FEAT_L;
   assign w_depthMax  = r_depth == MAX_DEPTH_L;
   assign w_goLeft    = w_feat <= w_thr;

   // Out-of-range feature indices select zero; they are flagged as errors anyway.
   always_comb begin
      w_feat = '0;
      for (int i = 0; i < NUM_FEAT; i++) begin
         if (w_featIdx == 4'(i)) w_feat = r_sample[i*FEAT_W +: FEAT_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE:    if (bus.in_valid) w_nextState = WALK;
         WALK:    if (!w_isInt || w_badFeat || w_depthMax) w_nextState = DONE;
         DONE:    if (bus.out_ready) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Node table only accepts writes while idle so a walk never sees a torn tree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NODES; n++) r_table[n] <= '0;
      end else if (r_state == IDLE && bus.cfg_we) begin
         r_table[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample   <= '0;
         r_curAddr  <= '0;
         r_depth    <= '0;
         r_outClass <= '0;
         r_outErr   <= 1'b0;
         r_outDepth <= '0;
         r_cfgErr   <= 1'b0;
      end else begin
         r_cfgErr <= bus.cfg_we && (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_sample  <= bus.in_x;
                  r_curAddr <= '0;
                  r_depth   <= '0;
               end
            end
            WALK: begin
               if (!w_isInt) begin
                  r_outClass <= w_leafClass;
                  r_outErr   <= 1'b0;
                  r_outDepth <= r_depth;
               end else if (w_badFeat || w_depthMax) begin
                  r_outClass <= '0;
                  r_outErr   <= 1'b1;
                  r_outDepth <= r_depth;
               end else begin
                  r_curAddr <= w_goLeft ? w_left : w_right;
                  r_depth   <= r_depth + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.out_class = r_outClass;
   assign bus.out_err   = r_outErr;
   assign bus.out_depth = r_outDepth;
   assign bus.cfg_err   = r_cfgErr;
endmodule

// File: tb/tb_dtree_serial_engine.sv
// Self-checking bench for dtree_serial_engine: fixed tree vectors, multi-cycle
// corner sequences, and random trees checked against a recursive-walk model.
module tb_dtree_serial_engine;
   localparam int NUM_FEAT = 9;
   localparam int FEAT_W   = 8;
   localparam int NODE_AW  = 6;
   localparam int CLASS_W  = 2;
   localparam int NW       = 1 + 4 + FEAT_W + 2 * NODE_AW;
   localparam int XW       = NUM_FEAT * FEAT_W;

   logic clk;
   logic rst_n;
   int   nCompared;
   int   nMismatched;
   logic [NW-1:0] mTable [64];

   dtree_serial_engine_if #(.NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW),
                            .CLASS_W(CLASS_W)) bus ();

   dtree_serial_engine #(.NUM_FEAT(NUM_FEAT), .FEAT_W(FEAT_W), .NODE_AW(NODE_AW),
                         .CLASS_W(CLASS_W), .MAX_DEPTH(15)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [XW-1:0] x;
      logic [1:0]    cls;
      logic          err;
      logic [3:0]    dep;
      int            lat;
   } vec_t;

   function automatic logic [NW-1:0] mkInt(input int feat, input int thr, input int l, input int r);
      return {1'b1, 4'(feat), 8'(thr), 6'(l), 6'(r)};
   endfunction

   function automatic logic [NW-1:0] mkLeaf(input int cls);
      return {23'b0, 2'(cls)};
   endfunction

   function automatic logic [XW-1:0] mkX(input int x2, input int x7);
      logic [XW-1:0] x;
      x = {NUM_FEAT{8'h33}};
      x[2*8 +: 8] = 8'(x2);
      x[7*8 +: 8] = 8'(x7);
      return x;
   endfunction

   // Reference walk: follow the tree from the root, applying the node rules directly.
   function automatic void modelClassify(input logic [XW-1:0] x, output logic [1:0] cls,
                                         output logic err, output int dep);
      int addr;
      int d;
      int f;
      logic [NW-1:0] w;
      addr = 0;
      d = 0;
      cls = 2'd0;
      err = 1'b1;
      dep = 0;
      for (int step = 0; step < 64; step++) begin
         w = mTable[addr];
         if (!w[NW-1]) begin
            cls = w[1:0];
            err = 1'b0;
            dep = d;
            return;
         end
         f = int'(w[23:20]);
         if (f >= NUM_FEAT || d == 15) begin
            cls = 2'd0;
            err = 1'b1;
            dep = d;
            return;
         end
         if (x[f*8 +: 8] <= w[19:12]) addr = int'(w[11:6]);
         else addr = int'(w[5:0]);
         d++;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic writeNode(input int addr, input logic [NW-1:0] word);
      @(negedge clk);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 6'(addr);
      bus.cfg_wdata = word;
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
      mTable[addr] = word;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!bus.out_valid && lat < 40);
      checkOutput("outValidSeen", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic finishDone();
      if (bus.out_ready && bus.out_valid) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [XW-1:0] x, output logic [1:0] cls, output logic err,
                                output logic [3:0] dep, output int lat);
      @(negedge clk);
      checkOutput("inReadyIdle", 32'(bus.in_ready), 32'd1);
      bus.in_x = x;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      waitResult(lat);
      cls = bus.out_class;
      err = bus.out_err;
      dep = bus.out_depth;
      finishDone();
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      for (int a = 0; a < 64; a++) mTable[a] = '0;
   endtask

   initial begin
      vec_t vecs[5];
      logic [1:0] cls, eCls;
      logic err, eErr;
      logic [3:0] dep;
      int eDep, lat;
      logic [XW-1:0] x;
      logic sawValid;

      nCompared = 0;
      nMismatched = 0;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_wdata = '0;
      bus.in_valid = 1'b0;
      bus.in_x = '0;
      bus.out_ready = 1'b1;
      doReset();
      #23;
      checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
      checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);
      checkOutput("rstCfgErr", 32'(bus.cfg_err), 32'd0);
      checkOutput("rstOutClass", 32'(bus.out_class), 32'd0);
      checkOutput("rstOutErr", 32'(bus.out_err), 32'd0);
      checkOutput("rstOutDepth", 32'(bus.out_depth), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus('0, cls, err, dep, lat);
      checkOutput("zeroClass", 32'(cls), 32'd0);
      checkOutput("zeroErr", 32'(err), 32'd0);
      checkOutput("zeroDepth", 32'(dep), 32'd0);
      checkOutput("zeroLat", 32'(lat), 32'd1);

      writeNode(0, mkInt(2, 71, 1, 2));
      writeNode(1, mkLeaf(1));
      writeNode(2, mkInt(7, 100, 3, 4));
      writeNode(3, mkLeaf(2));
      writeNode(4, mkLeaf(3));

      vecs[0] = '{mkX(71, 0),    2'd1, 1'b0, 4'd1, 2};
      vecs[1] = '{mkX(72, 101),  2'd3, 1'b0, 4'd2, 3};
      vecs[2] = '{mkX(200, 100), 2'd2, 1'b0, 4'd2, 3};
      vecs[3] = '{mkX(0, 255),   2'd1, 1'b0, 4'd1, 2};
      vecs[4] = '{mkX(255, 0),   2'd2, 1'b0, 4'd2, 3};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].x, cls, err, dep, lat);
         checkOutput($sformatf("vec%0dClass", i), 32'(cls), 32'(vecs[i].cls));
         checkOutput($sformatf("vec%0dErr", i), 32'(err), 32'(vecs[i].err));
         checkOutput($sformatf("vec%0dDepth", i), 32'(dep), 32'(vecs[i].dep));
         checkOutput($sformatf("vec%0dLat", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Back-pressure: result must hold while the consumer stalls.
      bus.out_ready = 1'b0;
      applyStimulus(mkX(72, 101), cls, err, dep, lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
         checkOutput("holdClass", 32'(bus.out_class), 32'd3);
         checkOutput("holdDepth", 32'(bus.out_depth), 32'd2);
         checkOutput("holdInReady", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("releaseInReady", 32'(bus.in_ready), 32'd1);
      checkOutput("releaseValid", 32'(bus.out_valid), 32'd0);

      writeNode(0, mkInt(12, 10, 1, 2));
      applyStimulus(mkX(5, 5), cls, err, dep, lat);
      checkOutput("badFeatErr", 32'(err), 32'd1);
      checkOutput("badFeatClass", 32'(cls), 32'd0);
      checkOutput("badFeatLat", 32'(lat), 32'd1);

      writeNode(0, mkInt(0, 255, 0, 0));
      applyStimulus(mkX(5, 5), cls, err, dep, lat);
      checkOutput("loopErr", 32'(err), 32'd1);
      checkOutput("loopClass", 32'(cls), 32'd0);
      checkOutput("loopDepth", 32'(dep), 32'd15);
      checkOutput("loopLat", 32'(lat), 32'd16);

      // Config write attempted mid-walk must be rejected and flagged.
      writeNode(0, mkInt(2, 71, 1, 2));
      @(negedge clk);
      bus.in_x = mkX(71, 0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 6'd1;
      bus.cfg_wdata = mkLeaf(0);
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
      checkOutput("cfgErrPulse", 32'(bus.cfg_err), 32'd1);
      checkOutput("busyWalk", 32'(bus.busy), 32'd1);
      waitResult(lat);
      checkOutput("cfgErrCleared", 32'(bus.cfg_err), 32'd0);
      checkOutput("walkCfgClass", 32'(bus.out_class), 32'd1);
      checkOutput("walkCfgLat", 32'(lat + 1), 32'd2);
      finishDone();
      applyStimulus(mkX(71, 0), cls, err, dep, lat);
      checkOutput("rerunClass", 32'(cls), 32'd1);

      // Reset during a long walk aborts it and clears the table.
      writeNode(0, mkInt(0, 255, 0, 0));
      @(negedge clk);
      bus.in_x = mkX(1, 1);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      doReset();
      #1;
      checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
      checkOutput("midRstValid", 32'(bus.out_valid), 32'd0);
      checkOutput("midRstInReady", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      sawValid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid) sawValid = 1'b1;
      end
      checkOutput("postRstNoValid", 32'(sawValid), 32'd0);
      applyStimulus(mkX(200, 0), cls, err, dep, lat);
      checkOutput("clearedClass", 32'(cls), 32'd0);
      checkOutput("clearedDepth", 32'(dep), 32'd0);
      checkOutput("clearedLat", 32'(lat), 32'd1);

      // Same-cycle write and accept: the walk must see the freshly written root.
      @(negedge clk);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 6'd0;
      bus.cfg_wdata = mkLeaf(2);
      bus.in_x = mkX(3, 3);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cfg_we = 1'b0;
      bus.in_valid = 1'b0;
      mTable[0] = mkLeaf(2);
      checkOutput("sameCycleCfgErr", 32'(bus.cfg_err), 32'd0);
      waitResult(lat);
      checkOutput("sameCycleClass", 32'(bus.out_class), 32'd2);
      checkOutput("sameCycleLat", 32'(lat), 32'd1);
      finishDone();

      for (int t = 0; t < 20; t++) begin
         for (int a = 0; a < 8; a++) begin
            if ($urandom_range(0, 2) == 0)
               writeNode(a, mkLeaf(int'($urandom_range(0, 3))));
            else
               writeNode(a, mkInt(int'($urandom_range(0, 10)), int'($urandom_range(0, 255)),
                                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
         end
         for (int s = 0; s < 10; s++) begin
            for (int f = 0; f < NUM_FEAT; f++) x[f*8 +: 8] = 8'($urandom_range(0, 255));
            modelClassify(x, eCls, eErr, eDep);
            applyStimulus(x, cls, err, dep, lat);
            checkOutput("rndClass", 32'(cls), 32'(eCls));
            checkOutput("rndErr", 32'(err), 32'(eErr));
            checkOutput("rndDepth", 32'(dep), 32'(eDep));
            checkOutput("rndLat", 32'(lat), 32'(eDep + 1));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
